riscv_id_ex_stage: RTL and testbench
====================================

Name: riscv_id_ex_stage

Overview:
- ID/EX pipeline register and EX operand-selection stage, directly upstream of riscv_alu.
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble.
- Drives operand_a, operand_b and alu_op straight into the ALU; carries rd/control fields onward to EX/MEM.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the instruction held in this stage (branch/jump redirect)
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage accepts the ID instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_src_a_sel  in  2  operand A source: 00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero)
- id_src_b_imm  in  1  operand B source: 1 imm, 0 rs2
- id_alu_op  in  4  ALU op code: 0 ADD … 9 SRA
- id_rd_addr  in  REG_ADDR_W  destination register index
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- ex_ready  in  1  EX/MEM accepts this stage's output
- exmem_rd_addr, memwb_rd_addr  in  REG_ADDR_W  forwarding source destination indices
- exmem_reg_write, memwb_reg_write  in  1  forwarding source write enables
- exmem_result, memwb_result  in  XLEN  forwarding source data
- ex_valid  out  1  stage holds a live instruction
- operand_a, operand_b  out  XLEN  to ALU
- alu_op  out  4  to ALU
- ex_store_data  out  XLEN  forwarded rs2 value, for stores
- ex_rd_addr  out  REG_ADDR_W  destination index
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control bits, each gated by ex_valid

Behaviour:
- Reset:
  - ex_valid=0, all registered fields 0, alu_op=0 (ADD).
  - With the register fields 0, the outputs are: operand_a=0, operand_b=0, ex_store_data=0, ex_rd_addr=0, controls=0.
- load_use is asserted when all of the following hold:
  - ex_valid && ex_mem_read_q && ex_rd_addr_q!=0
  - (id_rs1_addr==ex_rd_addr_q || id_rs2_addr==ex_rd_addr_q)
  - id_valid
- id_ready = (ex_ready || !ex_valid) && !load_use, combinational.
- Register update each cycle, in priority order:
  1. rst: reset state.
  2. flush: ex_valid<=0; fields don't-care. ID is not captured in the flush cycle, regardless of id_ready.
  3. ex_ready || !ex_valid:
     - load_use: ex_valid<=0 (one bubble).
     - otherwise: capture all id_* fields; ex_valid<=id_valid.
  4. Else (downstream stall): hold all registers.
- Latency: an instruction accepted in cycle N presents ALU operands in cycle N+1.
- Forwarding (combinational, on registered rs addresses). Per source s∈{rs1,rs2}, first match wins:
  1. exmem_reg_write && exmem_rd_addr!=0 && exmem_rd_addr==s → exmem_result
  2. memwb_reg_write && memwb_rd_addr!=0 && memwb_rd_addr==s → memwb_result
  3. otherwise the registered register-file data
- x0 is never forwarded.
- operand_a = mux(src_a_sel_q: fwd_rs1, pc_q, 0, 0).
- operand_b = src_b_imm_q ? imm_q : fwd_rs2.
- ex_store_data = fwd_rs2 regardless of src_b_imm.
- While held (ex_ready=0), outputs re-evaluate forwarding every cycle; forwarded values are not latched.
- Reset or flush mid-stall drops the held instruction. No partial state survives.

Optional Feature:
- Macro: RISCV_ID_EX_FORWARD_EN
- Defined: forwarding and single-bubble load-use handling as above.
- Undefined:
  - Forwarding muxes removed; operands come from registered register-file data only.
  - Hazard rule widens: load_use is asserted whenever a live instruction in this stage, or a valid EX/MEM or MEM/WB entry, has reg_write=1, rd!=0 and rd matching id_rs1_addr or id_rs2_addr.
  - Bubbles are inserted until the match clears. Software-visible results are identical; only CPI changes.

Test Plan:
- Reset check: rst=1 for 2 cycles with id_valid=1 → ex_valid=0, operand_a=operand_b=0, alu_op=0, id_ready=1 after release.
- Basic capture: id rs1_data=5, rs2_data=3, src_a_sel=00, src_b_imm=0, alu_op=ADD, no forwarding match → next cycle operand_a=5, operand_b=3, alu_op=0, ex_valid=1.
- Forwarding priority: registered rs1=x7; exmem (rd=7, we=1, result=0x11111111) and memwb (rd=7, we=1, result=0x22222222) → operand_a=0x11111111. Deassert exmem we → 0x22222222. Repeat with rd=0 → register-file data used.
- Load-use: live lw x5 in stage, ID presents add rs1=x5 → id_ready=0 for exactly 1 cycle, bubble with ex_valid=0. The add enters the next cycle and takes x5 from memwb_result=0xDEADBEEF.
- Stall and flush: ex_ready=0 for 3 cycles → all outputs held, id_ready=0. Assert flush during the stall → ex_valid=0 next cycle, and no ID capture in that cycle.
- Immediate/PC path: src_a_sel=01, pc=0x00001000, src_b_imm=1, imm=0xFFFFFFFC → operand_a=0x00001000, operand_b=0xFFFFFFFC, ex_store_data still equals forwarded rs2.

Source files
------------

// File: rtl/riscv_id_ex_stage_if.sv
// ID/EX stage bus: the ID-side handshake, the EX/MEM and MEM/WB forwarding
// taps, and the ALU/EX-MEM side outputs.
// master = surrounding pipeline, slave = riscv_id_ex_stage.
interface riscv_id_ex_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [1:0]            id_src_a_sel;
  logic                  id_src_b_imm;
  logic [3:0]            id_alu_op;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  ex_ready;
  logic [REG_ADDR_W-1:0] exmem_rd_addr;
  logic [REG_ADDR_W-1:0] memwb_rd_addr;
  logic                  exmem_reg_write;
  logic                  memwb_reg_write;
  logic [XLEN-1:0]       exmem_result;
  logic [XLEN-1:0]       memwb_result;
  logic                  ex_valid;
  logic [XLEN-1:0]       operand_a;
  logic [XLEN-1:0]       operand_b;
  logic [3:0]            alu_op;
  logic [XLEN-1:0]       ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;

  modport master (
    output flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data,
           id_rs2_data, id_imm, id_src_a_sel, id_src_b_imm, id_alu_op,
           id_rd_addr, id_reg_write, id_mem_read, id_mem_write, ex_ready,
           exmem_rd_addr, memwb_rd_addr, exmem_reg_write, memwb_reg_write,
           exmem_result, memwb_result,
    input  id_ready, ex_valid, operand_a, operand_b, alu_op, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data,
           id_rs2_data, id_imm, id_src_a_sel, id_src_b_imm, id_alu_op,
           id_rd_addr, id_reg_write, id_mem_read, id_mem_write, ex_ready,
           exmem_rd_addr, memwb_rd_addr, exmem_reg_write, memwb_reg_write,
           exmem_result, memwb_result,
    output id_ready, ex_valid, operand_a, operand_b, alu_op, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/riscv_id_ex_stage.sv
// ID/EX pipeline register plus EX operand selection feeding riscv_alu.
// Optional macro RISCV_ID_EX_FORWARD_EN: when defined, operands are forwarded
// from EX/MEM and MEM/WB and only load-use costs a single bubble. When
// undefined, operands come from register-file data only and ID stalls while
// any in-flight writer (this stage, EX/MEM, MEM/WB) targets one of its sources.
module riscv_id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  riscv_id_ex_stage_if.slave bus
);

  logic                  valid_reg;
  logic [XLEN-1:0]       pc_reg;
  logic [XLEN-1:0]       rs1_data_reg;
  logic [XLEN-1:0]       rs2_data_reg;
  logic [XLEN-1:0]       imm_reg;
  logic [1:0]            src_a_sel_reg;
  logic                  src_b_imm_reg;
  logic [3:0]            alu_op_reg;
  logic [REG_ADDR_W-1:0] rd_addr_reg;
  logic                  reg_write_reg;
  logic                  mem_read_reg;
  logic                  mem_write_reg;
`ifdef RISCV_ID_EX_FORWARD_EN
  logic [REG_ADDR_W-1:0] rs1_addr_reg;
  logic [REG_ADDR_W-1:0] rs2_addr_reg;
`endif

  logic                  load_use;
  logic [XLEN-1:0]       src_data [2];
  logic [XLEN-1:0]       fwd_data [2];

  // True when an in-flight writer targets one of the ID source registers.
  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] rd,
                                   input logic                  we);
    return we && (rd != '0) &&
           ((rd == bus.id_rs1_addr) || (rd == bus.id_rs2_addr));
  endfunction

  // Hazard detection on the incoming ID instruction.
  always_comb begin
    load_use = 1'b0;
`ifdef RISCV_ID_EX_FORWARD_EN
    load_use = bus.id_valid && valid_reg && mem_read_reg &&
               src_hit(rd_addr_reg, 1'b1);
`else
    load_use = bus.id_valid &&
               (src_hit(rd_addr_reg, valid_reg && reg_write_reg) ||
                src_hit(bus.exmem_rd_addr, bus.exmem_reg_write) ||
                src_hit(bus.memwb_rd_addr, bus.memwb_reg_write));
`endif
  end

  assign bus.id_ready = (bus.ex_ready || !valid_reg) && !load_use;

  // Pipeline register: reset, then flush, then advance (bubble on hazard), else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      rs1_data_reg  <= '0;
      rs2_data_reg  <= '0;
      imm_reg       <= '0;
      src_a_sel_reg <= 2'b00;
      src_b_imm_reg <= 1'b0;
      alu_op_reg    <= 4'd0;
      rd_addr_reg   <= '0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
`ifdef RISCV_ID_EX_FORWARD_EN
      rs1_addr_reg  <= '0;
      rs2_addr_reg  <= '0;
`endif
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
    end else if (bus.ex_ready || !valid_reg) begin
      if (load_use) begin
        valid_reg <= 1'b0;
      end else begin
        valid_reg     <= bus.id_valid;
        pc_reg        <= bus.id_pc;
        rs1_data_reg  <= bus.id_rs1_data;
        rs2_data_reg  <= bus.id_rs2_data;
        imm_reg       <= bus.id_imm;
        src_a_sel_reg <= bus.id_src_a_sel;
        src_b_imm_reg <= bus.id_src_b_imm;
        alu_op_reg    <= bus.id_alu_op;
        rd_addr_reg   <= bus.id_rd_addr;
        reg_write_reg <= bus.id_reg_write;
        mem_read_reg  <= bus.id_mem_read;
        mem_write_reg <= bus.id_mem_write;
`ifdef RISCV_ID_EX_FORWARD_EN
        rs1_addr_reg  <= bus.id_rs1_addr;
        rs2_addr_reg  <= bus.id_rs2_addr;
`endif
      end
    end
  end

  assign src_data[0] = rs1_data_reg;
  assign src_data[1] = rs2_data_reg;

  // Per-source operand resolution; EX/MEM beats MEM/WB, x0 never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef RISCV_ID_EX_FORWARD_EN
      logic [REG_ADDR_W-1:0] src_addr;
      assign src_addr = (gi == 0) ? rs1_addr_reg : rs2_addr_reg;
      assign fwd_data[gi] =
        (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) &&
         (bus.exmem_rd_addr == src_addr)) ? bus.exmem_result :
        (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
         (bus.memwb_rd_addr == src_addr)) ? bus.memwb_result :
        src_data[gi];
`else
      assign fwd_data[gi] = src_data[gi];
`endif
    end
  endgenerate

  // Operand A source select; the reserved encoding reads as zero.
  always_comb begin
    bus.operand_a = '0;
    case (src_a_sel_reg)
      2'b00:   bus.operand_a = fwd_data[0];
      2'b01:   bus.operand_a = pc_reg;
      default: bus.operand_a = '0;
    endcase
  end

  assign bus.operand_b     = src_b_imm_reg ? imm_reg : fwd_data[1];
  assign bus.ex_store_data = fwd_data[1];
  assign bus.alu_op        = alu_op_reg;
  assign bus.ex_valid      = valid_reg;
  assign bus.ex_rd_addr    = rd_addr_reg;
  assign bus.ex_reg_write  = valid_reg && reg_write_reg;
  assign bus.ex_mem_read   = valid_reg && mem_read_reg;
  assign bus.ex_mem_write  = valid_reg && mem_write_reg;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Directed bench for riscv_id_ex_stage. Expected values are hand-computed;
// where forwarding changes what is visible, both macro settings are covered.
module tb_riscv_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef RISCV_ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  riscv_id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  riscv_id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [1:0] asel, input logic bimm, input logic [3:0] op,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = rs1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs1_data  = d1;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_src_a_sel = asel;
    bus.id_src_b_imm = bimm;
    bus.id_alu_op    = op;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic [4:0] exrd, input logic exwe, input logic [31:0] exres,
                         input logic [4:0] wbrd, input logic wbwe, input logic [31:0] wbres);
    bus.exmem_rd_addr   = exrd;
    bus.exmem_reg_write = exwe;
    bus.exmem_result    = exres;
    bus.memwb_rd_addr   = wbrd;
    bus.memwb_reg_write = wbwe;
    bus.memwb_result    = wbres;
  endtask

  initial begin
    rst      = 1'b1;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    present(32'h40, 5'd1, 5'd2, 32'hAA, 32'hBB, 32'h7, 2'd0, 1'b0, 4'd3, 5'd4, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with ID valid
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_op_a", bus.operand_a, 32'h0);
    check("rst_op_b", bus.operand_b, 32'h0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    rst = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    check("rst_id_ready", 32'(bus.id_ready), 32'd1);

    // Basic capture: 5 + 3
    present(32'h100, 5'd1, 5'd2, 32'd5, 32'd3, 32'h0, 2'd0, 1'b0, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    check("cap_id_ready", 32'(bus.id_ready), 32'd1);
    step();
    check("cap_valid", 32'(bus.ex_valid), 32'd1);
    check("cap_op_a", bus.operand_a, 32'd5);
    check("cap_op_b", bus.operand_b, 32'd3);
    check("cap_alu_op", 32'(bus.alu_op), 32'd0);
    check("cap_store", bus.ex_store_data, 32'd3);
    check("cap_rd", 32'(bus.ex_rd_addr), 32'd3);
    check("cap_we", 32'(bus.ex_reg_write), 32'd1);

    // Forwarding on a held SUB x9, x7, x8
    present(32'h104, 5'd7, 5'd8, 32'h70, 32'h80, 32'h0, 2'd0, 1'b0, 4'd1, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    bus.ex_ready = 1'b0;
    bus.id_valid = 1'b0;
    set_fwd(5'd7, 1'b1, 32'h11111111, 5'd7, 1'b1, 32'h22222222);
    #1;
    check("fwd_exmem", bus.operand_a, FWD ? 32'h11111111 : 32'h70);
    set_fwd(5'd7, 1'b0, 32'h11111111, 5'd7, 1'b1, 32'h22222222);
    #1;
    check("fwd_memwb", bus.operand_a, FWD ? 32'h22222222 : 32'h70);
    set_fwd(5'd0, 1'b1, 32'h11111111, 5'd7, 1'b1, 32'h22222222);
    #1;
    check("fwd_x0_exmem", bus.operand_a, FWD ? 32'h22222222 : 32'h70);
    set_fwd(5'd0, 1'b1, 32'h11111111, 5'd0, 1'b1, 32'h22222222);
    #1;
    check("fwd_x0_both", bus.operand_a, 32'h70);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd8, 1'b1, 32'h33333333);
    #1;
    check("fwd_rs2_op_b", bus.operand_b, FWD ? 32'h33333333 : 32'h80);
    check("fwd_rs2_store", bus.ex_store_data, FWD ? 32'h33333333 : 32'h80);
    step();
    check("fwd_hold_alu", 32'(bus.alu_op), 32'd1);
    check("fwd_hold_valid", 32'(bus.ex_valid), 32'd1);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    check("fwd_release", bus.operand_b, 32'h80);
    bus.ex_ready = 1'b1;

    // Load-use: lw x5, 4(x1) then add x10, x5, x6
    present(32'h200, 5'd1, 5'd0, 32'h1000, 32'h0, 32'h4, 2'd0, 1'b1, 4'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    check("lu_lw_ready", 32'(bus.id_ready), 32'd1);
    step();
    check("lu_lw_mem_read", 32'(bus.ex_mem_read), 32'd1);
    check("lu_lw_op_a", bus.operand_a, 32'h1000);
    check("lu_lw_op_b", bus.operand_b, 32'h4);
    present(32'h204, 5'd5, 5'd6, 32'h0, 32'h60, 32'h0, 2'd0, 1'b0, 4'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_ready_low", 32'(bus.id_ready), 32'd0);
    step();
    set_fwd(5'd5, 1'b1, 32'h1004, 5'd0, 1'b0, 32'h0);
    #1;
    check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check("lu_bubble_mem_read", 32'(bus.ex_mem_read), 32'd0);
`ifdef RISCV_ID_EX_FORWARD_EN
    check("lu_ready_back", 32'(bus.id_ready), 32'd1);
    step();
    set_fwd(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF);
    #1;
`else
    check("lu_ready_exmem", 32'(bus.id_ready), 32'd0);
    step();
    set_fwd(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF);
    #1;
    check("lu_bubble2_valid", 32'(bus.ex_valid), 32'd0);
    check("lu_ready_memwb", 32'(bus.id_ready), 32'd0);
    step();
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    bus.id_rs1_data = 32'hDEADBEEF;
    #1;
    check("lu_ready_back", 32'(bus.id_ready), 32'd1);
    step();
`endif
    check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_add_op_a", bus.operand_a, 32'hDEADBEEF);
    check("lu_add_op_b", bus.operand_b, 32'h60);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

    // Downstream stall for three cycles, then flush
    bus.ex_ready = 1'b0;
    present(32'h300, 5'd1, 5'd2, 32'h111, 32'h222, 32'h0, 2'd0, 1'b0, 4'd2, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    check("st_ready", 32'(bus.id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("st%0d_valid", i), 32'(bus.ex_valid), 32'd1);
      check($sformatf("st%0d_rd", i), 32'(bus.ex_rd_addr), 32'd10);
      check($sformatf("st%0d_op_b", i), bus.operand_b, 32'h60);
      check($sformatf("st%0d_ready", i), 32'(bus.id_ready), 32'd0);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check("fl_valid", 32'(bus.ex_valid), 32'd0);
    check("fl_reg_write", 32'(bus.ex_reg_write), 32'd0);
    check("fl_ready", 32'(bus.id_ready), 32'd1);
    bus.ex_ready = 1'b1;
    step();
    check("fl_cap_valid", 32'(bus.ex_valid), 32'd1);
    check("fl_cap_rd", 32'(bus.ex_rd_addr), 32'd11);
    check("fl_cap_alu", 32'(bus.alu_op), 32'd2);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl2_valid", 32'(bus.ex_valid), 32'd0);

    // PC / immediate operand paths
    present(32'h1000, 5'd1, 5'd8, 32'h55, 32'h80, 32'hFFFFFFFC, 2'd1, 1'b1, 4'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    step();
    check("pc_op_a", bus.operand_a, 32'h00001000);
    check("imm_op_b", bus.operand_b, 32'hFFFFFFFC);
    check("imm_store", bus.ex_store_data, 32'h80);
    bus.id_valid = 1'b0;
    set_fwd(5'd0, 1'b0, 32'h0, 5'd8, 1'b1, 32'h44444444);
    #1;
    check("imm_store_fwd", bus.ex_store_data, FWD ? 32'h44444444 : 32'h80);
    check("imm_op_b_fwd", bus.operand_b, 32'hFFFFFFFC);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    present(32'h2000, 5'd1, 5'd2, 32'h99, 32'h0, 32'h0, 2'd2, 1'b0, 4'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    step();
    check("zero_op_a", bus.operand_a, 32'h0);
    present(32'h2004, 5'd1, 5'd2, 32'h99, 32'h0, 32'h0, 2'd3, 1'b0, 4'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    step();
    check("rsvd_op_a", bus.operand_a, 32'h0);
    check("rsvd_rd", 32'(bus.ex_rd_addr), 32'd14);

    // Reset during a stall drops the held instruction
    bus.ex_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    check("rst2_valid", 32'(bus.ex_valid), 32'd0);
    check("rst2_op_a", bus.operand_a, 32'h0);
    check("rst2_store", bus.ex_store_data, 32'h0);
    check("rst2_rd", 32'(bus.ex_rd_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
